// File: rtl/adder.sv
// Registered unsigned N-bit adder: sum and carry-out appear one clock after the operands.
// The outputs clear asynchronously while rst is high.
module adder #(
    parameter int unsigned N = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned W = N + 1;

    logic [W-1:0] total_c;

    // Zero-extend both operands so the top bit of the (N+1)-bit result is the carry.
    always_comb begin
        total_c = {1'b0, input1} + {1'b0, input2};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= total_c[N-1:0];
            cout <= total_c[N];
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: directed vectors with literal expectations, plus an
// arithmetic reference model compared against N=9, N=1 and N=16 instances on every cycle.
module tb_adder;

    logic        clk;
    logic        rst;
    logic [8:0]  a9, b9;
    logic [8:0]  sum9;
    logic        cout9;
    logic [0:0]  a1, b1;
    logic [0:0]  sum1;
    logic        cout1;
    logic [15:0] a16, b16;
    logic [15:0] sum16;
    logic        cout16;

    int n_cmp = 0;
    int n_bad = 0;

    adder #(.N(9)) u_dut9 (
        .clk(clk), .rst(rst), .input1(a9), .input2(b9), .sum(sum9), .cout(cout9)
    );
    adder #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst), .input1(a1), .input2(b1), .sum(sum1), .cout(cout1)
    );
    adder #(.N(16)) u_dut16 (
        .clk(clk), .rst(rst), .input1(a16), .input2(b16), .sum(sum16), .cout(cout16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer addition, modulo 2^N, carry when the total reaches 2^N.
    longint m9_sum, m1_sum, m16_sum;
    bit     m9_cout, m1_cout, m16_cout;
    bit     model_ok = 1'b0;

    always @(posedge clk or posedge rst) begin
        longint t;
        if (rst) begin
            m9_sum = 0;  m9_cout = 1'b0;
            m1_sum = 0;  m1_cout = 1'b0;
            m16_sum = 0; m16_cout = 1'b0;
            model_ok = 1'b1;
        end else begin
            t = longint'(a9) + longint'(b9);
            m9_sum = t % 512;    m9_cout = (t >= 512);
            t = longint'(a1) + longint'(b1);
            m1_sum = t % 2;      m1_cout = (t >= 2);
            t = longint'(a16) + longint'(b16);
            m16_sum = t % 65536; m16_cout = (t >= 65536);
        end
    end

    // Compare all instances against the model on each falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("model_sum9",   longint'(sum9),   m9_sum);
            check("model_cout9",  longint'(cout9),  longint'(m9_cout));
            check("model_sum1",   longint'(sum1),   m1_sum);
            check("model_cout1",  longint'(cout1),  longint'(m1_cout));
            check("model_sum16",  longint'(sum16),  m16_sum);
            check("model_cout16", longint'(cout16), longint'(m16_cout));
        end
    end

    task automatic step(input logic [8:0] a, input logic [8:0] b);
        a9 = a;
        b9 = b;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic [8:0] s;
        logic       c;
    } vec_t;

    vec_t stream[5];

    initial begin
        stream[0] = '{9'h000, 9'h000, 9'h000, 1'b0};
        stream[1] = '{9'h000, 9'h1FE, 9'h1FE, 1'b0};
        stream[2] = '{9'h1FC, 9'h1FF, 9'h1FB, 1'b1};
        stream[3] = '{9'h1FF, 9'h007, 9'h006, 1'b1};
        stream[4] = '{9'h00F, 9'h000, 9'h00F, 1'b0};

        rst = 1'b1;
        a9 = 9'h1FF; b9 = 9'h1FF;
        a1 = 1'b0;   b1 = 1'b0;
        a16 = 16'h0; b16 = 16'h0;
        #1;
        check("rst_sum_initial",  longint'(sum9),  0);
        check("rst_cout_initial", longint'(cout9), 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum_clocked",  longint'(sum9),  0);
        check("rst_cout_clocked", longint'(cout9), 0);

        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_sum",  longint'(sum9),  'h1FE);
        check("rst_release_cout", longint'(cout9), 1);

        // Basic add: outputs hold until the capturing edge.
        a9 = 9'h000; b9 = 9'h1FE;
        #1;
        check("basic_hold_sum",  longint'(sum9),  'h1FE);
        check("basic_hold_cout", longint'(cout9), 1);
        @(posedge clk);
        #1;
        check("basic_sum",  longint'(sum9),  'h1FE);
        check("basic_cout", longint'(cout9), 0);

        step(9'h1FF, 9'h001);
        check("wrap1_sum",  longint'(sum9),  'h000);
        check("wrap1_cout", longint'(cout9), 1);
        step(9'h1FC, 9'h1FF);
        check("wrap2_sum",  longint'(sum9),  'h1FB);
        check("wrap2_cout", longint'(cout9), 1);

        for (int i = 0; i < 5; i++) begin
            step(stream[i].a, stream[i].b);
            check($sformatf("stream%0d_sum", i),  longint'(sum9),  longint'(stream[i].s));
            check($sformatf("stream%0d_cout", i), longint'(cout9), longint'(stream[i].c));
        end

        // Mid-stream reset between edges must clear without a clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_clr_sum",  longint'(sum9),  0);
        check("async_clr_cout", longint'(cout9), 0);
        a9 = 9'h1FC; b9 = 9'h1FF;
        @(posedge clk);
        #1;
        check("in_reset_sum", longint'(sum9), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("resume_sum",  longint'(sum9),  'h1FB);
        check("resume_cout", longint'(cout9), 1);

        // Width sweep on the N=1 and N=16 instances.
        a1 = 1'b1; b1 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'h0001;
        step(9'h003, 9'h004);
        check("n1_sum",   longint'(sum1),   0);
        check("n1_cout",  longint'(cout1),  1);
        check("n16_sum",  longint'(sum16),  'h0000);
        check("n16_cout", longint'(cout16), 1);
        check("n9_small", longint'(sum9),   'h007);
        a1 = 1'b1; b1 = 1'b0;
        a16 = 16'h1234; b16 = 16'h4321;
        step(9'h100, 9'h0FF);
        check("n1b_sum",   longint'(sum1),   1);
        check("n1b_cout",  longint'(cout1),  0);
        check("n16b_sum",  longint'(sum16),  'h5555);
        check("n16b_cout", longint'(cout16), 0);
        check("n9_top",    longint'(sum9),   'h1FF);

        // Held operands keep the outputs steady across several edges.
        repeat (3) @(posedge clk);
        #1;
        check("hold_sum",  longint'(sum9),  'h1FF);
        check("hold_cout", longint'(cout9), 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion before 100000");
        $fatal(1);
    end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
- REQ-001: Parameter N, default 9: operand and result width in bits; legal range 1..64.
- REQ-002: clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-003: rst, input, 1 bit: asynchronous, active-high reset.
- REQ-004: input1, input, N bits: unsigned operand A.
- REQ-005: input2, input, N bits: unsigned operand B.
- REQ-006: sum, output, N bits, registered: (input1 + input2) mod 2^N.
- REQ-007: cout, output, 1 bit, registered: carry out of bit N-1 of input1 + input2.

Function
- REQ-008: The block SHALL compute input1 + input2 as an unsigned (N+1)-bit value.
  - Bits [N-1:0] of the result SHALL go to sum.
  - Bit N of the result SHALL go to cout.
- REQ-009: sum and cout SHALL be driven directly from flip-flops.
  - They SHALL update on every rising clk edge while rst is low.
  - Latency SHALL be exactly 1 cycle: operands present before edge k appear on sum/cout after edge k.
- REQ-010: There SHALL be no enable and no handshake; a new operand pair SHALL be accepted every cycle (throughput 1 per cycle).
- REQ-011: Wrap-around: when the sum is at least 2^N, sum SHALL be the low N bits and cout SHALL be 1. There is no saturation.
- REQ-012: Operands held constant SHALL leave sum and cout constant, with no glitches on the registered outputs.
- REQ-013: The block SHALL have no carry-in and no signed mode; all arithmetic is unsigned.
- REQ-014: The adder logic SHALL be purely combinational between the input ports and the output registers. There are no input registers.
- REQ-015: Operands containing X/Z are outside the contract. After valid operands return, the outputs SHALL be correct from the next edge onward.

Reset
- REQ-016: While rst is high, sum SHALL be 0 and cout SHALL be 0, independent of clk. The outputs SHALL clear immediately on rst assertion.
- REQ-017: rst asserted mid-operation SHALL discard the in-flight result. No value computed before reset SHALL appear after reset.
- REQ-018: On the first rising clk edge after rst deasserts, the outputs SHALL capture the current operands. From there, normal 1-cycle latency applies.
- REQ-019: Reset deassertion SHALL be treated as asynchronous.
  - The integrator guarantees recovery/removal timing relative to clk.
  - The block SHALL contain no internal reset synchronizer.

Verification (N=9)
- REQ-020: Reset check: hold rst=1 with input1=0x1FF and input2=0x1FF, toggling clk.
  - Required: sum=0x000 and cout=0 throughout.
  - After rst deasserts and one edge: sum=0x1FE, cout=1.
- REQ-021: Basic add: input1=0x000 and input2=0x1FE applied before edge k.
  - Required: sum=0x1FE, cout=0 after edge k.
  - Outputs hold the previous value before edge k.
- REQ-022: Carry/wrap: input1=0x1FF, input2=0x001 -> sum=0x000, cout=1.
  - Second pair: input1=0x1FC, input2=0x1FF -> sum=0x1FB, cout=1.
- REQ-023: Back-to-back stream: change the operands every cycle through the pairs below.
  - (0x000,0x000) -> 0x000/0
  - (0x000,0x1FE) -> 0x1FE/0
  - (0x1FC,0x1FF) -> 0x1FB/1
  - (0x1FF,0x007) -> 0x006/1
  - (0x00F,0x000) -> 0x00F/0
  - Required: each result appears exactly one edge after its operands.
- REQ-024: Mid-stream reset: assert rst asynchronously between edges while sum is nonzero.
  - Required: sum and cout go to 0 immediately, without waiting for a clk edge.
  - Required: correct results resume one edge after deassertion.
- REQ-025: Parameter sweep: N=1 with operands 1+1 -> sum=0, cout=1.
  - N=16 with 0xFFFF+0x0001 -> sum=0x0000, cout=1.
